seq_alu: RTL and testbench

Parametrised, multi-cycle successor to the combinational execute-stage ALU. Single-cycle logic/arithmetic ops keep their existing 4-bit encodings. Adds iterative unsigned multiply and divide/remainder (shift-add, restoring division). Sits in the EX stage behind a valid/ready handshake so the pipeline control can stall on long ops and flush on branch mispredict.

---
 rtl/seq_alu.sv | 160 ++++++++++++++++
 tb/tb_seq_alu.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle execute-stage ALU behind a valid/ready handshake.
//
// Single-cycle ops (AND/OR/ADD/SUB/SLT/NOR, unknown codes, divide-by-zero) finish in the accept
// cycle. MUL/MULHU use shift-add and DIVU/REMU use restoring division, one step per cycle for
// XLEN cycles. The result is held in DONE until the consumer takes it.
//
// Ports:
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   flush        synchronous abort of any in-flight op (result register retained)
//   in_valid/in_ready, a, b, alu_ctrl   operation request
//   out_valid/out_ready, result         registered result handshake
//   zero         result == 0
module seq_alu #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      alu_ctrl,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam int unsigned CntW = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(XLEN - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] op_a_q, op_a_d;
  logic [XLEN-1:0] op_b_q, op_b_d;
  // op_q[1]: divide family, op_q[0]: high half / remainder
  logic [1:0]      op_q, op_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            is_multi, is_div, div_by_zero;
  logic [XLEN-1:0] sc_result;
  logic [XLEN:0]   mul_sum, div_shift, div_diff;
  logic [XLEN-1:0] hi_step, lo_step;

  // Single-cycle result, computed straight from the request
  always_comb begin
    sc_result = '0;
    case (alu_ctrl)
      4'b0000: sc_result = a & b;
      4'b0001: sc_result = a | b;
      4'b0010: sc_result = a + b;
      4'b0110: sc_result = a - b;
      4'b0111: sc_result = {{(XLEN-1){1'b0}}, (a < b)};
      4'b1100: sc_result = ~(a | b);
      4'b1010: sc_result = '1;  // only reached when b == 0
      4'b1011: sc_result = a;   // only reached when b == 0
      default: sc_result = '0;
    endcase
  end

  assign is_multi    = (alu_ctrl[3:2] == 2'b10);
  assign is_div      = (alu_ctrl[3:1] == 3'b101);
  assign div_by_zero = is_div && (b == '0);

  // One iteration step. {hi, lo} is the product (multiplier shifts out of lo) or the
  // partial remainder / quotient pair (dividend shifts out of lo, quotient bits shift in).
  always_comb begin
    mul_sum   = {1'b0, hi_q} + ({1'b0, op_a_q} & {(XLEN+1){lo_q[0]}});
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, op_b_q};
    if (op_q[1]) begin
      // Top bit of the difference is the borrow: set means restore
      hi_step = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
      lo_step = {lo_q[XLEN-2:0], ~div_diff[XLEN]};
    end else begin
      hi_step = mul_sum[XLEN:1];
      lo_step = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    op_d     = op_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    if (flush) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            op_a_d = a;
            op_b_d = b;
            op_d   = alu_ctrl[1:0];
            if (is_multi && !div_by_zero) begin
              hi_d    = '0;
              lo_d    = is_div ? a : b;
              cnt_d   = '0;
              state_d = StBusy;
            end else begin
              result_d = sc_result;
              state_d  = StDone;
            end
          end
        end
        StBusy: begin
          hi_d = hi_step;
          lo_d = lo_step;
          if (cnt_q == CntLast) begin
            result_d = op_q[0] ? hi_step : lo_step;
            state_d  = StDone;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StDone: begin
          if (out_ready) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      op_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      op_q     <= op_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign zero      = (result_q == '0);

endmodule

// File: tb/tb_seq_alu.sv
// Testbench for seq_alu: directed cases on an XLEN=32 instance, random traffic with random
// consumer backpressure on an XLEN=8 instance, both against an arithmetic reference model.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst;
  int          checks = 0;
  int          errors = 0;

  // XLEN = 32 instance
  logic        fl32, v32, ir32, ov32, or32, z32;
  logic [31:0] a32, b32, r32;
  logic [3:0]  c32;
  // XLEN = 8 instance
  logic        fl8, v8, ir8, ov8, or8, z8;
  logic [7:0]  a8, b8, r8;
  logic [3:0]  c8;

  logic [31:0] last32;

  always #5 clk = ~clk;

  seq_alu #(.XLEN(32)) u_dut32 (
    .clk(clk), .rst(rst), .flush(fl32), .in_valid(v32), .in_ready(ir32), .a(a32), .b(b32),
    .alu_ctrl(c32), .out_valid(ov32), .out_ready(or32), .result(r32), .zero(z32)
  );

  seq_alu #(.XLEN(8)) u_dut8 (
    .clk(clk), .rst(rst), .flush(fl8), .in_valid(v8), .in_ready(ir8), .a(a8), .b(b8),
    .alu_ctrl(c8), .out_valid(ov8), .out_ready(or8), .result(r8), .zero(z8)
  );

  // Reference: plain unsigned arithmetic on 64-bit values, truncated to w bits
  function automatic logic [31:0] ref_res(input logic [3:0] c, input logic [31:0] x,
                                          input logic [31:0] y, input int w);
    longint unsigned m, xa, yb, r;
    m  = (64'd1 << w) - 64'd1;
    xa = longint'(x) & m;
    yb = longint'(y) & m;
    case (c)
      4'd0:    r = xa & yb;
      4'd1:    r = xa | yb;
      4'd2:    r = xa + yb;
      4'd6:    r = xa - yb;
      4'd7:    r = (xa < yb) ? 64'd1 : 64'd0;
      4'd12:   r = ~(xa | yb);
      4'd8:    r = xa * yb;
      4'd9:    r = (xa * yb) >> w;
      4'd10:   r = (yb == 0) ? m : xa / yb;
      4'd11:   r = (yb == 0) ? xa : xa % yb;
      default: r = 64'd0;
    endcase
    return 32'(r & m);
  endfunction

  // Cycles from accept edge until out_valid is seen
  function automatic int ref_lat(input logic [3:0] c, input logic [31:0] y, input int w);
    longint unsigned m;
    m = (64'd1 << w) - 64'd1;
    if (c >= 4'd8 && c <= 4'd11 && !(c >= 4'd10 && (longint'(y) & m) == 0)) return w + 1;
    return 1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op on the 32-bit instance, check latency/result/zero, then hand it off
  task automatic do32(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                      input string tag);
    logic [31:0] exp;
    int n;
    exp = ref_res(c, x, y, 32);
    a32 = x; b32 = y; c32 = c; v32 = 1'b1;
    step();
    v32 = 1'b0; a32 = $urandom; b32 = $urandom; c32 = 4'($urandom);
    n = 1;
    while (!ov32 && n < 100) begin
      step();
      n++;
    end
    chk({tag, " latency"}, 64'(n), 64'(ref_lat(c, y, 32)));
    chk({tag, " result"}, 64'(r32), 64'(exp));
    chk({tag, " zero"}, 64'(z32), 64'(exp == 0));
    or32 = 1'b1;
    step();
    or32 = 1'b0;
    chk({tag, " handoff"}, {62'd0, ov32, ir32}, 64'b01);
    last32 = exp;
  endtask

  // Same on the 8-bit instance, with random out_ready while the result is pending
  task automatic do8(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                     input string tag);
    logic [31:0] exp;
    int n, k;
    logic taken;
    exp = ref_res(c, x, y, 8);
    a8 = x[7:0]; b8 = y[7:0]; c8 = c; v8 = 1'b1;
    step();
    v8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    n = 1;
    while (!ov8 && n < 50) begin
      step();
      n++;
    end
    chk({tag, " latency"}, 64'(n), 64'(ref_lat(c, y, 8)));
    chk({tag, " result"}, 64'(r8), 64'(exp[7:0]));
    chk({tag, " zero"}, 64'(z8), 64'(exp[7:0] == 8'd0));
    taken = 1'b0;
    k = 0;
    while (!taken && k < 8) begin
      or8 = 1'($urandom_range(0, 1));
      v8  = 1'($urandom_range(0, 1));  // must be ignored while in DONE
      step();
      taken = or8;
      k++;
      if (!taken) chk({tag, " hold"}, {53'd0, ov8, ir8, r8}, {53'd0, 1'b1, 1'b0, exp[7:0]});
    end
    v8 = 1'b0;
    if (!taken) begin
      or8 = 1'b1;
      step();
    end
    or8 = 1'b0;
    chk({tag, " handoff"}, {62'd0, ov8, ir8}, 64'b01);
  endtask

  initial begin
    int n;
    logic seen;
    logic [3:0] rc;
    logic [31:0] rx, ry;
    rst = 1'b1;
    fl32 = 0; v32 = 0; or32 = 0; a32 = 0; b32 = 0; c32 = 0;
    fl8 = 0;  v8 = 0;  or8 = 0;  a8 = 0;  b8 = 0;  c8 = 0;
    last32 = 0;
    #12;
    chk("reset32", {60'd0, ir32, ov32, z32, 1'b0} | 64'(r32) << 4, 64'b1010);
    chk("reset8", {60'd0, ir8, ov8, z8, 1'b0} | 64'(r8) << 4, 64'b1010);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Single-cycle class
    do32(4'b0010, 32'hFFFF_FFFF, 32'd1, "add_wrap");
    do32(4'b0110, 32'd5, 32'd7, "sub");
    do32(4'b0111, 32'd3, 32'h8000_0000, "slt");
    do32(4'b0111, 32'h8000_0000, 32'd3, "slt_false");
    do32(4'b1100, 32'd0, 32'd0, "nor");
    do32(4'b0000, 32'hF0F0_1234, 32'h0FF0_FFFF, "and");
    do32(4'b0001, 32'hF000_0000, 32'h0000_000F, "or");
    do32(4'b0011, 32'h1234_5678, 32'h9ABC_DEF0, "unknown");
    // Multi-cycle class
    do32(4'b1000, 32'h0001_0000, 32'h0001_0000, "mul_lo");
    do32(4'b1001, 32'h0001_0000, 32'h0001_0000, "mulhu");
    do32(4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_max");
    do32(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_max");
    do32(4'b1010, 32'd100, 32'd7, "divu");
    do32(4'b1011, 32'd100, 32'd7, "remu");
    do32(4'b1010, 32'hFFFF_FFFF, 32'h8000_0001, "divu_big");
    do32(4'b1010, 32'd9, 32'd0, "divu_by0");
    do32(4'b1011, 32'd9, 32'd0, "remu_by0");

    // Backpressure: result held for 10 cycles, new requests ignored
    a32 = 32'd40; b32 = 32'd2; c32 = 4'b0010; v32 = 1'b1;
    step();
    a32 = 32'd1; b32 = 32'd1;  // keep in_valid high with different operands
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold", {29'd0, ov32, ir32, z32, r32}, {29'd0, 1'b1, 1'b0, 1'b0, 32'd42});
      step();
    end
    v32 = 1'b0;
    or32 = 1'b1;
    step();
    or32 = 1'b0;
    chk("bp_release", {62'd0, ov32, ir32}, 64'b01);
    last32 = 32'd42;

    // Flush at BUSY cycle 10 of a divide
    a32 = 32'd100; b32 = 32'd7; c32 = 4'b1010; v32 = 1'b1;
    step();
    v32 = 1'b0;
    repeat (10) step();
    fl32 = 1'b1;
    v32 = 1'b1;  // coincident request must not be accepted
    a32 = 32'd1; b32 = 32'd1; c32 = 4'b0010;
    step();
    fl32 = 1'b0;
    v32 = 1'b0;
    chk("flush_idle", {61'd0, ov32, ir32, 1'b0} | 64'(r32) << 3, {61'd0, 3'b010} |
        64'(last32) << 3);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      seen = seen | ov32;
      step();
    end
    chk("flush_no_out", 64'(seen), 64'd0);
    do32(4'b0010, 32'd2, 32'd3, "add_after_flush");

    // Asynchronous reset in the middle of a multiply
    a32 = 32'd123; b32 = 32'd456; c32 = 4'b1000; v32 = 1'b1;
    step();
    v32 = 1'b0;
    repeat (5) step();
    #2 rst = 1'b1;
    #1;
    chk("async_rst", {29'd0, ir32, ov32, z32, r32}, {29'd0, 3'b101, 32'd0});
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      seen = seen | ov32;
      step();
    end
    chk("rst_no_out", 64'(seen), 64'd0);

    // XLEN = 8 directed
    do8(4'b1000, 32'h10, 32'h10, "x8_mul");
    do8(4'b1001, 32'h10, 32'h10, "x8_mulhu");
    do8(4'b1011, 32'hFF, 32'h0D, "x8_remu");

    // Random traffic
    for (int i = 0; i < 200; i++) begin
      rc = 4'($urandom_range(0, 15));
      rx = $urandom;
      ry = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      do32(rc, rx, ry, "rnd32");
    end
    for (int i = 0; i < 5000; i++) begin
      rc = 4'($urandom_range(0, 15));
      rx = $urandom;
      ry = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      do8(rc, rx, ry, "rnd8");
      n = $urandom_range(0, 2);
      repeat (n) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
